clock_enable_sequencer: RTL and testbench
=========================================

// Module: clock_enable_sequencer
// PURPOSE
//   Consumer side of the PLL clock generator. Runs on the PLL GENCLK output and watches PLL LOCK.
//   Holds the system reset until lock is stable, then releases it and produces single-cycle clock
//   enables at /2, /4, /8. These enables replace ripple-divided clocks for all downstream logic.
//   On loss of lock it re-asserts system reset and counts the loss.
// PARAMETERS
//   LOCK_STABLE_CYCLES  1024  cycles the synchronised LOCK must stay high before reset hold starts
//   RESET_HOLD_CYCLES   16    cycles SYS_RESETB stays low after lock is deemed stable
// PORTS
//   CLK         in   1  PLL GENCLK; the only clock
//   RESETB      in   1  synchronous, active-low reset
//   PLL_LOCK    in   1  PLL LOCK, asynchronous to CLK
//   SYS_RESETB  out  1  synchronous active-low reset for the rest of the design
//   READY       out  1  high while in RUN
//   CE_DIV2     out  1  1-cycle enable every 2nd cycle in RUN
//   CE_DIV4     out  1  1-cycle enable every 4th cycle in RUN
//   CE_DIV8     out  1  1-cycle enable every 8th cycle in RUN
//   LOSS_COUNT  out  4  count of lock losses while in RUN; saturates at 15
// BEHAVIOUR
//   - Single clock CLK. Reset is synchronous and active-low on RESETB.
//   - RESETB=0 at an edge forces: state=WAIT_LOCK, all counters=0, SYS_RESETB=0, READY=0, CE_*=0,
//     LOSS_COUNT=0, synchroniser flops=0. This applies in any state, including mid-RUN.
//   - PLL_LOCK passes through a 2-flop synchroniser to give lock_s (2 edges of latency).
//   - FSM states: WAIT_LOCK, STABLE, HOLD, RUN.
//     WAIT_LOCK: when lock_s=1, go to STABLE with stable_cnt=0.
//     STABLE: stable_cnt increments each cycle while lock_s=1. When it reaches LOCK_STABLE_CYCLES-1,
//       go to HOLD with hold_cnt=0. If lock_s=0, go to WAIT_LOCK; no loss is counted.
//     HOLD: hold_cnt increments each cycle. At RESET_HOLD_CYCLES-1, go to RUN.
//       If lock_s=0, go to WAIT_LOCK; no loss is counted.
//     RUN: if lock_s=0, go to WAIT_LOCK and increment LOSS_COUNT (saturating at 15).
//   - Edge budget from the first edge that samples PLL_LOCK=1 to the first RUN edge:
//     2 (sync) + 1 (WAIT_LOCK) + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES.
//   - SYS_RESETB and READY are registered and equal (state==RUN). Both go low on the same edge
//     that leaves RUN.
//   - div_cnt[2:0] is held at 0 outside RUN. In RUN it increments by 1 each cycle, wrapping 7->0.
//     The first RUN cycle has div_cnt=0.
//   - Enable decode (RUN only, from registered state and div_cnt, glitch-free):
//     CE_DIV2=div_cnt[0]; CE_DIV4=&div_cnt[1:0]; CE_DIV8=&div_cnt[2:0].
//     So CE_DIV8 implies CE_DIV4, and CE_DIV4 implies CE_DIV2.
//     First pulses in RUN: DIV2 in cycle 1, DIV4 in cycle 3, DIV8 in cycle 7.
//   - Leaving RUN forces all CE_* low in the same cycle as SYS_RESETB falls. No partial pulse.
//   - Counter widths are $clog2 of the respective parameter. Parameters must be >= 1.
// STRUCTURE
//   - Package relojes_pkg: seq_state_t enum {WAIT_LOCK, STABLE, HOLD, RUN}, DIV_BITS=3,
//     LOSS_MAX=4'd15.
//   - Sub-module sync_2ff (1-bit two-flop synchroniser, reset value 0) for PLL_LOCK.
//   - Everything else (FSM, counters, enable decode) lives in this module.
// TESTING  (bench parameters LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4)
//   1. Hold RESETB=0 for 4 edges, then set RESETB=1 with PLL_LOCK=1 constant.
//      -> SYS_RESETB and READY rise exactly 15 edges after release; CE_* stay 0 until then.
//   2. Drop PLL_LOCK for 1 cycle during STABLE.
//      -> FSM returns to WAIT_LOCK, the full 15-edge budget restarts from re-lock, LOSS_COUNT stays 0.
//   3. In RUN, observe 16 cycles.
//      -> CE_DIV2 pulses 8 times, CE_DIV4 4 times, CE_DIV8 2 times (RUN cycles 7 and 15),
//         each pulse 1 cycle wide.
//   4. In RUN, drop PLL_LOCK.
//      -> SYS_RESETB, READY and CE_* go low on the 3rd edge after the drop; LOSS_COUNT goes 0->1.
//      -> Re-lock reaches RUN after another 15 edges.
//   5. Cause 17 RUN->lock-loss events.
//      -> LOSS_COUNT reads 15 and holds at 15.
//   6. Assert RESETB=0 mid-RUN while div_cnt=5.
//      -> At the next edge all outputs take reset values and LOSS_COUNT=0.
//      -> After release, PLL_LOCK=1 reaches RUN in 15 edges with div_cnt restarting at 0.

Source files
------------

// File: rtl/relojes_pkg.sv
// Shared types and constants for the PLL-consumer clock enable sequencer.
package relojes_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        HOLD,
        RUN
    } seq_state_t;

    localparam int         DIV_BITS = 3;
    localparam logic [3:0] LOSS_MAX = 4'd15;

    // Counter width for a terminal count of n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_enable_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser with a synchronous active-low clear to 0.
module sync_2ff (
    input  logic clk,
    input  logic resetb,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clock_enable_sequencer.sv
// Holds system reset until PLL lock is stable, then issues /2, /4, /8 clock enables;
// drops back to reset on lock loss and counts those losses.
module clock_enable_sequencer
    import relojes_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16
) (
    input  logic       CLK,
    input  logic       RESETB,
    input  logic       PLL_LOCK,
    output logic       SYS_RESETB,
    output logic       READY,
    output logic       CE_DIV2,
    output logic       CE_DIV4,
    output logic       CE_DIV8,
    output logic [3:0] LOSS_COUNT
);

    localparam int STABLE_W = cnt_width(LOCK_STABLE_CYCLES);
    localparam int HOLD_W   = cnt_width(RESET_HOLD_CYCLES);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RESET_HOLD_CYCLES - 1);

    seq_state_t          state;
    logic                lock_s;
    logic [STABLE_W-1:0] stable_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [DIV_BITS-1:0] div_cnt;
    logic [DIV_BITS-1:0] div_next;

    sync_2ff u_lock_sync (
        .clk    (CLK),
        .resetb (RESETB),
        .d      (PLL_LOCK),
        .q      (lock_s)
    );

    assign div_next = div_cnt + DIV_BITS'(1);

    // Outputs are registered from the next state, so they switch on the same edge as the FSM.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
            hold_cnt   <= '0;
            div_cnt    <= '0;
            SYS_RESETB <= 1'b0;
            READY      <= 1'b0;
            CE_DIV2    <= 1'b0;
            CE_DIV4    <= 1'b0;
            CE_DIV8    <= 1'b0;
            LOSS_COUNT <= 4'd0;
        end else begin
            SYS_RESETB <= 1'b0;
            READY      <= 1'b0;
            CE_DIV2    <= 1'b0;
            CE_DIV4    <= 1'b0;
            CE_DIV8    <= 1'b0;
            div_cnt    <= '0;
            case (state)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state      <= STABLE;
                        stable_cnt <= '0;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (stable_cnt == STABLE_LAST) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + STABLE_W'(1);
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= RUN;
                        SYS_RESETB <= 1'b1;
                        READY      <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        if (LOSS_COUNT != LOSS_MAX) begin
                            LOSS_COUNT <= LOSS_COUNT + 4'd1;
                        end
                    end else begin
                        SYS_RESETB <= 1'b1;
                        READY      <= 1'b1;
                        div_cnt    <= div_next;
                        CE_DIV2    <= div_next[0];
                        CE_DIV4    <= &div_next[1:0];
                        CE_DIV8    <= &div_next;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Directed self-checking bench for clock_enable_sequencer with short lock/hold parameters.
`timescale 1ns/1ps
module tb_clock_enable_sequencer;

    localparam int LSC = 8;
    localparam int RHC = 4;

    logic       CLK = 1'b0;
    logic       RESETB;
    logic       PLL_LOCK;
    logic       SYS_RESETB;
    logic       READY;
    logic       CE_DIV2;
    logic       CE_DIV4;
    logic       CE_DIV8;
    logic [3:0] LOSS_COUNT;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    clock_enable_sequencer #(
        .LOCK_STABLE_CYCLES (LSC),
        .RESET_HOLD_CYCLES  (RHC)
    ) dut (
        .CLK        (CLK),
        .RESETB     (RESETB),
        .PLL_LOCK   (PLL_LOCK),
        .SYS_RESETB (SYS_RESETB),
        .READY      (READY),
        .CE_DIV2    (CE_DIV2),
        .CE_DIV4    (CE_DIV4),
        .CE_DIV8    (CE_DIV8),
        .LOSS_COUNT (LOSS_COUNT)
    );

    // Packed view: {SYS_RESETB, READY, CE_DIV2, CE_DIV4, CE_DIV8, LOSS_COUNT[3:0]}
    function automatic logic [15:0] pk(input logic s, input logic r, input logic c2,
                                       input logic c4, input logic c8, input logic [3:0] l);
        return {7'b0, s, r, c2, c4, c8, l};
    endfunction

    function automatic logic [15:0] dutOut();
        return pk(SYS_RESETB, READY, CE_DIV2, CE_DIV4, CE_DIV8, LOSS_COUNT);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic rb, input logic lock);
        RESETB   = rb;
        PLL_LOCK = lock;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 14 edges still in reset, RUN entered on the 15th edge after lock is first sampled.
    task automatic runBudget(input string tag, input logic [3:0] loss);
        for (int e = 1; e < 15; e++) begin
            tick();
            checkOutput({tag, "_held"}, dutOut(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, loss));
        end
        tick();
        checkOutput({tag, "_run"}, dutOut(), pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, loss));
    endtask

    initial begin
        int n2, n4, n8;
        logic [3:0] k4;
        logic [3:0] exp_loss;

        applyStimulus(1'b0, 1'b0);
        tick(4);
        checkOutput("reset_state", dutOut(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));

        // Lock glitch while in STABLE restarts the whole budget without counting a loss
        applyStimulus(1'b1, 1'b1);
        tick(5);
        checkOutput("stable_pre_glitch", dutOut(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1);
        runBudget("stable_glitch", 4'd0);

        applyStimulus(1'b0, 1'b1);
        tick(4);
        checkOutput("reset_from_run", dutOut(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        applyStimulus(1'b1, 1'b1);
        runBudget("power_up", 4'd0);

        n2 = 0; n4 = 0; n8 = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            k4 = 4'(k);
            checkOutput("run_ce", dutOut(), pk(1'b1, 1'b1, k4[0], &k4[1:0], &k4[2:0], 4'd0));
            n2 += int'(CE_DIV2);
            n4 += int'(CE_DIV4);
            n8 += int'(CE_DIV8);
        end
        checkOutput("div2_pulses", 16'(n2), 16'd8);
        checkOutput("div4_pulses", 16'(n4), 16'd4);
        checkOutput("div8_pulses", 16'(n8), 16'd2);

        // Lock loss in RUN: two edges of synchroniser latency, then reset on the third
        applyStimulus(1'b1, 1'b0);
        tick();
        checkOutput("loss_edge1", dutOut(), pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0));
        tick();
        checkOutput("loss_edge2", dutOut(), pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
        tick();
        checkOutput("loss_edge3", dutOut(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1));
        applyStimulus(1'b1, 1'b1);
        runBudget("relock", 4'd1);

        for (int n = 2; n <= 17; n++) begin
            exp_loss = (n > 15) ? 4'd15 : 4'(n);
            applyStimulus(1'b1, 1'b0);
            tick(3);
            checkOutput("loss_event", dutOut(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_loss));
            applyStimulus(1'b1, 1'b1);
            tick(15);
            checkOutput("loss_relock", dutOut(), pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, exp_loss));
        end
        checkOutput("loss_saturated", 16'(LOSS_COUNT), 16'd15);

        tick(5);
        checkOutput("div_cnt5", dutOut(), pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd15));
        applyStimulus(1'b0, 1'b1);
        tick();
        checkOutput("midrun_reset", dutOut(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        applyStimulus(1'b1, 1'b1);
        runBudget("after_reset", 4'd0);
        tick();
        checkOutput("restart_cycle1", dutOut(), pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
        tick(2);
        checkOutput("restart_cycle3", dutOut(), pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
